// File: rtl/lpc_autocorr_if.sv
// rtl/lpc_autocorr_if.sv - sample-in / autocorrelation-out handshake bundle for lpc_autocorr
interface lpc_autocorr_if #(
    parameter int DATA_W = 16
);
    logic                     s_valid;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_ready;
    logic                     r_valid;
    logic [3:0]               r_idx;
    logic signed [DATA_W-1:0] r_data;
    logic                     r_ready;
    logic signed [5:0]        nrm_shift;
    logic                     zero_frame;
    logic                     busy;

    modport master (
        output s_valid, s_data, r_ready,
        input  s_ready, r_valid, r_idx, r_data, nrm_shift, zero_frame, busy
    );

    modport slave (
        input  s_valid, s_data, r_ready,
        output s_ready, r_valid, r_idx, r_data, nrm_shift, zero_frame, busy
    );
endinterface

// File: rtl/lpc_autocorr.sv
// rtl/lpc_autocorr.sv - frame autocorrelation R[0..ORDER] with block normalisation on R[0]
module lpc_autocorr #(
    parameter int DATA_W    = 16,
    parameter int ORDER     = 10,
    parameter int FRAME_LEN = 240,
    parameter int ACC_W     = 40
) (
    input  logic           clk,
    input  logic           rst,
    lpc_autocorr_if.slave  bus
);
    localparam int ADDR_W = $clog2(FRAME_LEN);
    localparam int CNT_W  = $clog2(FRAME_LEN + 2);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {S_FILL, S_MAC, S_NORM1, S_NORM2, S_OUT} state_t;

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        wr_cnt;
    logic [3:0]               lag;
    logic [CNT_W-1:0]         cyc;
    logic [CNT_W-1:0]         lag_len;
    logic                     issue, lag_done;
    logic [ADDR_W-1:0]        addr_a, addr_b;

    logic signed [DATA_W-1:0] mem [FRAME_LEN];
    logic signed [DATA_W-1:0] rd_a, rd_b;
    logic                     v1, v2;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, acc, acc_sum;
    logic signed [ACC_W-1:0]  bank [ORDER+1];

    logic [5:0]               msb_p, msb_q;
    logic signed [5:0]        shift_q;
    logic [5:0]               shamt;
    logic                     zero_q;
    logic [3:0]               idx_q;
    logic signed [ACC_W-1:0]  sel;
    logic signed [DATA_W-1:0] norm_dat;

    // Lag k pairs x[cyc+k] with x[cyc] for cyc < N-k, then two drain cycles empty the pipe.
    always_comb begin
        lag_len  = CNT_W'(FRAME_LEN) - CNT_W'(lag);
        issue    = (state == S_MAC) && (cyc < lag_len);
        lag_done = (state == S_MAC) && (cyc == lag_len + CNT_W'(1));
        addr_a   = ADDR_W'(cyc) + ADDR_W'(lag);
        addr_b   = ADDR_W'(cyc);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_sum  = v2 ? acc + prod_ext : acc;
    end

    always_comb begin
        msb_p = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (bank[0][i]) msb_p = 6'(i);
        end
    end

    always_comb begin
        sel      = bank[idx_q];
        shamt    = shift_q[5] ? 6'(-shift_q) : 6'(shift_q);
        norm_dat = shift_q[5] ? DATA_W'(sel <<< shamt) : DATA_W'(sel >>> shamt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FILL;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:  if (bus.s_valid && wr_cnt == ADDR_W'(FRAME_LEN - 1)) state_nxt = S_MAC;
            S_MAC:   if (lag_done && lag == 4'(ORDER)) state_nxt = S_NORM1;
            S_NORM1: state_nxt = S_NORM2;
            S_NORM2: state_nxt = S_OUT;
            S_OUT:   if (bus.r_ready && idx_q == 4'(ORDER)) state_nxt = S_FILL;
            default: state_nxt = S_FILL;
        endcase
    end

    // Sample buffer has no reset so it can map onto a two-read-port RAM.
    always_ff @(posedge clk) begin
        if (state == S_FILL && bus.s_valid) mem[wr_cnt] <= bus.s_data;
        if (issue) begin
            rd_a <= mem[addr_a];
            rd_b <= mem[addr_b];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt  <= '0;
            lag     <= '0;
            cyc     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            prod    <= '0;
            acc     <= '0;
            msb_q   <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
            idx_q   <= '0;
            for (int i = 0; i <= ORDER; i++) bank[i] <= '0;
        end else begin
            v1 <= issue;
            v2 <= v1;
            if (v1) prod <= rd_a * rd_b;
            case (state)
                S_FILL: begin
                    if (bus.s_valid)
                        wr_cnt <= (wr_cnt == ADDR_W'(FRAME_LEN - 1)) ? '0 : wr_cnt + 1'b1;
                end
                S_MAC: begin
                    if (lag_done) begin
                        bank[lag] <= acc_sum;
                        acc       <= '0;
                        cyc       <= '0;
                        lag       <= (lag == 4'(ORDER)) ? '0 : lag + 1'b1;
                    end else begin
                        acc <= acc_sum;
                        cyc <= cyc + 1'b1;
                    end
                end
                S_NORM1: msb_q <= msb_p;
                S_NORM2: begin
                    if (bank[0] == '0) begin
                        shift_q <= '0;
                        zero_q  <= 1'b1;
                    end else begin
                        shift_q <= $signed(msb_q - 6'd14);
                        zero_q  <= 1'b0;
                    end
                    idx_q <= '0;
                end
                S_OUT: begin
                    if (bus.r_ready && idx_q != 4'(ORDER)) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready    = (state == S_FILL);
    assign bus.busy       = (state != S_FILL);
    assign bus.r_valid    = (state == S_OUT);
    assign bus.r_idx      = idx_q;
    assign bus.r_data     = (state == S_OUT) ? norm_dat : '0;
    assign bus.nrm_shift  = shift_q;
    assign bus.zero_frame = zero_q;
endmodule

// File: tb/tb_lpc_autocorr.sv
// tb/tb_lpc_autocorr.sv - scoreboard bench for lpc_autocorr
module tb_lpc_autocorr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lpc_autocorr_if #(.DATA_W(16)) bus ();
    lpc_autocorr dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int samp [240];
    logic signed [15:0] exp_q [$];
    logic signed [5:0]  exp_shift_q [$];
    logic               exp_zero_q [$];

    function automatic void model();
        longint r [11];
        longint val;
        int p, sh;
        logic signed [15:0] t;
        for (int k = 0; k <= 10; k++) begin
            r[k] = 0;
            for (int n = k; n < 240; n++) r[k] += longint'(samp[n]) * longint'(samp[n-k]);
        end
        p = 0;
        for (int b = 0; b < 40; b++) if (((r[0] >> b) & 64'sd1) != 0) p = b;
        sh = (r[0] == 0) ? 0 : p - 14;
        exp_shift_q.push_back(6'(sh));
        exp_zero_q.push_back(r[0] == 0);
        for (int k = 0; k <= 10; k++) begin
            val = (sh >= 0) ? (r[k] >>> sh) : (r[k] <<< (-sh));
            t = val[15:0];
            exp_q.push_back(t);
        end
    endfunction

    task automatic send_frame(input bit push);
        int cnt;
        for (int n = 0; n < 240; n++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(samp[n]);
            cnt = 0;
            while (bus.s_ready !== 1'b1 && cnt < 5000) begin
                @(negedge clk);
                cnt++;
            end
            if (bus.s_ready !== 1'b1) begin
                errors++;
                $display("FAIL s_ready_timeout sample=%0d s_ready=%b required=1", n, bus.s_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        if (push) model();
    endtask

    task automatic receive_frame(input int stall_idx, input int stall_cyc);
        int cnt;
        logic signed [15:0] e;
        for (int i = 0; i <= 10; i++) begin
            cnt = 0;
            while (bus.r_valid !== 1'b1 && cnt < 5000) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (bus.r_valid !== 1'b1) begin
                errors++;
                $display("FAIL r_valid_timeout idx=%0d r_valid=%b required=1", i, bus.r_valid);
                return;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty idx=%0d got=%0d required=queued_result", i, bus.r_data);
                return;
            end
            e = exp_q.pop_front();
            if (i == 0) begin
                checks += 2;
                if (bus.nrm_shift !== exp_shift_q[0]) begin
                    errors++;
                    $display("FAIL nrm_shift got=%0d required=%0d", bus.nrm_shift, exp_shift_q[0]);
                end
                if (bus.zero_frame !== exp_zero_q[0]) begin
                    errors++;
                    $display("FAIL zero_frame got=%b required=%b", bus.zero_frame, exp_zero_q[0]);
                end
                void'(exp_shift_q.pop_front());
                void'(exp_zero_q.pop_front());
            end
            checks += 2;
            if (bus.r_idx !== 4'(i)) begin
                errors++;
                $display("FAIL r_idx got=%0d required=%0d", bus.r_idx, i);
            end
            if (bus.r_data !== e) begin
                errors++;
                $display("FAIL r_data idx=%0d got=%0d required=%0d", i, bus.r_data, e);
            end
            if (i == stall_idx) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    @(negedge clk);
                    checks++;
                    if (bus.r_valid !== 1'b1 || bus.r_idx !== 4'(i) || bus.r_data !== e) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d got=v%b/i%0d/d%0d required=v1/i%0d/d%0d",
                                 s, bus.r_valid, bus.r_idx, bus.r_data, i, e);
                    end
                end
            end
            bus.r_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.r_ready = 1'b0;
        end
        checks++;
        if (bus.r_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL return_fill got=r_valid%b/s_ready%b required=r_valid0/s_ready1",
                     bus.r_valid, bus.s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.s_ready !== 1'b1)  begin errors++; $display("FAIL rst_s_ready got=%b required=1", bus.s_ready); end
        if (bus.r_valid !== 1'b0)  begin errors++; $display("FAIL rst_r_valid got=%b required=0", bus.r_valid); end
        if (bus.r_idx !== 4'd0)    begin errors++; $display("FAIL rst_r_idx got=%0d required=0", bus.r_idx); end
        if (bus.r_data !== 16'sd0) begin errors++; $display("FAIL rst_r_data got=%0d required=0", bus.r_data); end
        if (bus.nrm_shift !== 6'sd0) begin errors++; $display("FAIL rst_nrm_shift got=%0d required=0", bus.nrm_shift); end
        if (bus.zero_frame !== 1'b0) begin errors++; $display("FAIL rst_zero_frame got=%b required=0", bus.zero_frame); end
        if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got=%b required=0", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        for (int n = 0; n < 240; n++) samp[n] = (n == 0) ? 16384 : 0;
        send_frame(1'b1);
        receive_frame(-1, 0);
    endtask

    task automatic test_dc();
        int lat;
        for (int n = 0; n < 240; n++) samp[n] = 256;
        send_frame(1'b1);
        checks += 2;
        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL mac_s_ready got=%b required=0", bus.s_ready); end
        if (bus.busy !== 1'b1)    begin errors++; $display("FAIL mac_busy got=%b required=1", bus.busy); end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (bus.r_valid !== 1'b1 && lat < 5000);
        checks++;
        if (lat != 2609) begin errors++; $display("FAIL latency got=%0d required=2609", lat); end
        receive_frame(-1, 0);
    endtask

    task automatic test_alternating();
        for (int n = 0; n < 240; n++) samp[n] = (n % 2 == 0) ? 1000 : -1000;
        send_frame(1'b1);
        receive_frame(-1, 0);
    endtask

    task automatic test_zero();
        for (int n = 0; n < 240; n++) samp[n] = 0;
        send_frame(1'b1);
        receive_frame(-1, 0);
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 240; n++) samp[n] = (n % 17) * 300 - 2400;
        send_frame(1'b1);
        receive_frame(3, 5);
    endtask

    task automatic test_small_left_shift();
        for (int n = 0; n < 240; n++) samp[n] = int'($urandom_range(0, 6)) - 3;
        send_frame(1'b1);
        receive_frame(-1, 0);
    endtask

    task automatic test_reset_mid_mac();
        for (int n = 0; n < 240; n++) samp[n] = int'($urandom_range(0, 2000)) - 1000;
        send_frame(1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL abort_s_ready got=%b required=1", bus.s_ready); end
        if (bus.busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got=%b required=0", bus.busy); end
        if (bus.r_valid !== 1'b0) begin errors++; $display("FAIL abort_r_valid got=%b required=0", bus.r_valid); end
        rst = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 240; n++) samp[n] = 256;
        send_frame(1'b1);
        receive_frame(-1, 0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 240; n++) samp[n] = int'($urandom_range(0, 65535)) - 32768;
            send_frame(1'b1);
            receive_frame(-1, 0);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.r_ready = 1'b0;
        test_reset();
        test_impulse();
        test_dc();
        test_alternating();
        test_zero();
        test_backpressure();
        test_small_left_shift();
        test_reset_mid_mac();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
